// File: rtl/joy_port.sv
// Two-port NES-style pad interface: synchronized pads with turbo, $4016 strobe and serial shift-out.
// Reads are combinational; strobe and shift registers update on ce edges; no backpressure.
module joy_port #(
    parameter int          TURBO_DIV = 3,
    parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic        vs,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    output logic [7:0]  dout,
    output logic        dout_en
);

    localparam logic [15:0] LP_ADDR_P1 = 16'h4016;
    localparam logic [15:0] LP_ADDR_P2 = 16'h4017;
    localparam logic [3:0]  LP_LAST    = 4'(TURBO_DIV - 1);

    logic [9:0] r_joy1_s1, r_joy1_s2;
    logic [9:0] r_joy2_s1, r_joy2_s2;
    logic       r_vs_s1, r_vs_s2, r_vs_d;
    logic [3:0] r_frame_cnt;
    logic       r_turbo;
    logic       r_strobe;
    logic [7:0] r_sr1, r_sr2;

    logic       w_vs_rise;
    logic [7:0] w_eff1, w_eff2;
    logic       w_hit_p1, w_hit_p2;
    logic       w_wr_p1;
    logic       w_unused;

    // Z/Mode and the upper write-data bits have no function here.
    assign w_unused = ^{joy1[11:10], joy2[11:10], cpu_o[7:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_joy1_s1 <= '0;
            r_joy1_s2 <= '0;
            r_joy2_s1 <= '0;
            r_joy2_s2 <= '0;
            r_vs_s1   <= 1'b0;
            r_vs_s2   <= 1'b0;
            r_vs_d    <= 1'b0;
        end else begin
            r_joy1_s1 <= joy1[9:0];
            r_joy1_s2 <= r_joy1_s1;
            r_joy2_s1 <= joy2[9:0];
            r_joy2_s2 <= r_joy2_s1;
            r_vs_s1   <= vs;
            r_vs_s2   <= r_vs_s1;
            r_vs_d    <= r_vs_s2;
        end
    end

    assign w_vs_rise = r_vs_s2 & ~r_vs_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_turbo     <= 1'b0;
        end else if (w_vs_rise) begin
            if (r_frame_cnt == LP_LAST) begin
                r_frame_cnt <= '0;
                r_turbo     <= ~r_turbo;
            end else begin
                r_frame_cnt <= r_frame_cnt + 4'd1;
            end
        end
    end

    // X and Y act as turbo A and B, gated by the frame phase.
    assign w_eff1 = {r_joy1_s2[7:2],
                     r_joy1_s2[1] | (r_joy1_s2[9] & r_turbo),
                     r_joy1_s2[0] | (r_joy1_s2[8] & r_turbo)};
    assign w_eff2 = {r_joy2_s2[7:2],
                     r_joy2_s2[1] | (r_joy2_s2[9] & r_turbo),
                     r_joy2_s2[0] | (r_joy2_s2[8] & r_turbo)};

    assign w_hit_p1 = (cpu_a == LP_ADDR_P1);
    assign w_hit_p2 = (cpu_a == LP_ADDR_P2);
    assign w_wr_p1  = cpu_w & w_hit_p1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe <= 1'b0;
            r_sr1    <= 8'hFF;
            r_sr2    <= 8'hFF;
        end else if (ce) begin
            if (w_wr_p1)
                r_strobe <= cpu_o[0];
            // Old strobe value governs, so the 1->0 write cycle still reloads.
            if (r_strobe) begin
                r_sr1 <= w_eff1;
                r_sr2 <= w_eff2;
            end else if (cpu_r && !cpu_w) begin
                if (w_hit_p1)
                    r_sr1 <= {1'b1, r_sr1[7:1]};
                else if (w_hit_p2)
                    r_sr2 <= {1'b1, r_sr2[7:1]};
            end
        end
    end

    assign dout_en = reset_n & cpu_r & (w_hit_p1 | w_hit_p2);

    always_comb begin
        dout = 8'h00;
        if (dout_en)
            dout = {OPEN_BUS[7:1], (w_hit_p2 ? r_sr2[0] : r_sr1[0])};
    end

endmodule

// File: tb/tb_joy_port.sv
// Directed bench for joy_port: vector table for serial reads plus sequences for sync, turbo, ce and reset.
module tb_joy_port;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_o;
    logic        cpu_r;
    logic        cpu_w;
    logic        vs;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic [7:0]  dout;
    logic        dout_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dat;
        logic        en;
    } vec_t;

    vec_t tbl [0:19];

    joy_port #(.TURBO_DIV(3), .OPEN_BUS(8'h40)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ce      (ce),
        .cpu_a   (cpu_a),
        .cpu_o   (cpu_o),
        .cpu_r   (cpu_r),
        .cpu_w   (cpu_w),
        .vs      (vs),
        .joy1    (joy1),
        .joy2    (joy2),
        .dout    (dout),
        .dout_en (dout_en)
    );

    always #20 clock = ~clock;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input logic exp_en, input string name);
        cpu_a = a;
        cpu_r = 1'b1;
        #5;
        check8(name, dout, exp);
        check8({name, "_en"}, {7'd0, dout_en}, {7'd0, exp_en});
        @(negedge clock);
        cpu_r = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_a = a;
        cpu_o = d;
        cpu_w = 1'b1;
        @(negedge clock);
        cpu_w = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic latch_pads();
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
    endtask

    initial begin
        logic [11:0] pat;

        // A+Start on port 1
        tbl[0]  = '{16'h4016, 8'h41, 1'b1};
        tbl[1]  = '{16'h4016, 8'h40, 1'b1};
        tbl[2]  = '{16'h4016, 8'h40, 1'b1};
        tbl[3]  = '{16'h4016, 8'h41, 1'b1};
        tbl[4]  = '{16'h4016, 8'h40, 1'b1};
        tbl[5]  = '{16'h4016, 8'h40, 1'b1};
        tbl[6]  = '{16'h4016, 8'h40, 1'b1};
        tbl[7]  = '{16'h4016, 8'h40, 1'b1};
        tbl[8]  = '{16'h4016, 8'h41, 1'b1};
        // Right on port 2, port 1 idle, interleaved
        tbl[9]  = '{16'h4017, 8'h40, 1'b1};
        tbl[10] = '{16'h4017, 8'h40, 1'b1};
        tbl[11] = '{16'h4017, 8'h40, 1'b1};
        tbl[12] = '{16'h4017, 8'h40, 1'b1};
        tbl[13] = '{16'h4016, 8'h40, 1'b1};
        tbl[14] = '{16'h4017, 8'h40, 1'b1};
        tbl[15] = '{16'h4017, 8'h40, 1'b1};
        tbl[16] = '{16'h4017, 8'h40, 1'b1};
        tbl[17] = '{16'h4016, 8'h40, 1'b1};
        tbl[18] = '{16'h4017, 8'h41, 1'b1};
        tbl[19] = '{16'h4015, 8'h00, 1'b0};

        reset_n = 1'b0;
        ce      = 1'b1;
        cpu_a   = 16'h4016;
        cpu_o   = 8'h00;
        cpu_r   = 1'b1;
        cpu_w   = 1'b0;
        vs      = 1'b0;
        joy1    = 12'h000;
        joy2    = 12'h000;
        #5;
        check8("rst_dout", dout, 8'h00);
        check8("rst_en", {7'd0, dout_en}, 8'h00);
        idle(2);
        cpu_r   = 1'b0;
        reset_n = 1'b1;
        idle(1);
        check8("idle_dout", dout, 8'h00);
        rd(16'h4016, 8'h41, 1'b1, "rst_sr1");
        rd(16'h4017, 8'h41, 1'b1, "rst_sr2");

        // Turbo: A follows X only in the odd phase, toggling every 3 frames
        pat  = 12'b111_000_111_000;
        joy1 = 12'h100;
        idle(4);
        for (int f = 0; f < 12; f++) begin
            latch_pads();
            rd(16'h4016, {7'h20, pat[f]}, 1'b1, $sformatf("turbo%0d", f));
            vs = 1'b1;
            idle(2);
            vs = 1'b0;
            idle(4);
        end

        joy1 = 12'h009;
        idle(4);
        latch_pads();
        for (int i = 0; i <= 8; i++)
            rd(tbl[i].a, tbl[i].dat, tbl[i].en, $sformatf("vec%0d", i));

        // Strobe held high: reads track A through the 2-flop synchronizer
        wr(16'h4016, 8'h01);
        joy1 = 12'h001;
        idle(4);
        rd(16'h4016, 8'h41, 1'b1, "live_a1");
        rd(16'h4016, 8'h41, 1'b1, "live_a1b");
        joy1 = 12'h000;
        idle(2);
        rd(16'h4016, 8'h41, 1'b1, "sync_lag");
        rd(16'h4016, 8'h40, 1'b1, "live_a0");
        joy1 = 12'h001;
        idle(4);
        rd(16'h4016, 8'h41, 1'b1, "live_a1c");

        joy1 = 12'h000;
        joy2 = 12'h080;
        idle(4);
        latch_pads();
        for (int i = 9; i <= 19; i++)
            rd(tbl[i].a, tbl[i].dat, tbl[i].en, $sformatf("vec%0d", i));

        // ce low: reads drive the bus but do not shift, writes are ignored
        joy1 = 12'h009;
        joy2 = 12'h000;
        idle(4);
        latch_pads();
        rd(16'h4016, 8'h41, 1'b1, "ce_b0");
        ce    = 1'b0;
        cpu_a = 16'h4016;
        cpu_r = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #5;
            check8($sformatf("ce0_dout%0d", k), dout, 8'h40);
            check8($sformatf("ce0_en%0d", k), {7'd0, dout_en}, 8'h01);
            @(negedge clock);
        end
        cpu_r = 1'b0;
        wr(16'h4016, 8'h01);
        ce = 1'b1;
        rd(16'h4016, 8'h40, 1'b1, "ce_b1");
        rd(16'h4016, 8'h40, 1'b1, "ce_b2");
        cpu_a = 16'h4016;
        cpu_o = 8'h00;
        cpu_r = 1'b1;
        cpu_w = 1'b1;
        @(negedge clock);
        cpu_r = 1'b0;
        cpu_w = 1'b0;
        rd(16'h4016, 8'h41, 1'b1, "rw_b3");
        wr(16'h4017, 8'h01);
        rd(16'h4016, 8'h40, 1'b1, "w4017_b4");

        // Reset in the middle of a read sequence
        latch_pads();
        rd(16'h4016, 8'h41, 1'b1, "mid_b0");
        rd(16'h4016, 8'h40, 1'b1, "mid_b1");
        rd(16'h4016, 8'h40, 1'b1, "mid_b2");
        cpu_a   = 16'h4016;
        cpu_r   = 1'b1;
        reset_n = 1'b0;
        #5;
        check8("mid_rst_dout", dout, 8'h00);
        check8("mid_rst_en", {7'd0, dout_en}, 8'h00);
        @(negedge clock);
        check8("mid_rst_en2", {7'd0, dout_en}, 8'h00);
        reset_n = 1'b1;
        cpu_r   = 1'b0;
        rd(16'h4016, 8'h41, 1'b1, "post_rst0");
        rd(16'h4016, 8'h41, 1'b1, "post_rst1");
        rd(16'h4016, 8'h41, 1'b1, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
